// File: rtl/image_capture_rgb565.sv
// ---------------------------------------------------------------------------
// image_capture_rgb565
//   Captures an 8-bit RGB565 camera byte stream into expanded 8/8/8 pixels
//   for the filter pipeline.  Frames are delimited by cam_vsync, lines by
//   cam_href; bytes arrive on single-cycle cam_byte_en strobes.  Optional 2:1
//   decimation in both axes keeps even source columns of even source lines.
//
// Parameters
//   IMG_WIDTH   output frame width in pixels
//   IMG_HEIGHT  output frame height in lines
//   DECIMATE    1 = keep even columns of even lines, 0 = keep every pixel
//
// Ports
//   clk, reset        system clock, synchronous active-high reset
//   cam_vsync         high during frame blanking (already in clk domain)
//   cam_href          line-active qualifier
//   cam_data          camera byte, meaningful only with cam_byte_en
//   cam_byte_en       one-cycle byte strobe
//   red_out, green_out, blue_out   expanded pixel colour (held between pixels)
//   valid_out         pixel qualifier, one cycle after the low byte
//   frame_start       with valid_out on the first pixel of a frame at (0,0)
//   x_out, y_out      output column / line of the current pixel
//   frame_done        one-cycle pulse when vsync rises on a captured frame
//   frame_error       qualifies frame_done: bad line count or bad line
// ---------------------------------------------------------------------------
module image_capture_rgb565 #(
  parameter int IMG_WIDTH  = 320,
  parameter int IMG_HEIGHT = 240,
  parameter bit DECIMATE   = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cam_vsync,
  input  logic       cam_href,
  input  logic [7:0] cam_data,
  input  logic       cam_byte_en,
  output logic [7:0] red_out,
  output logic [7:0] green_out,
  output logic [7:0] blue_out,
  output logic       valid_out,
  output logic       frame_start,
  output logic [8:0] x_out,
  output logic [7:0] y_out,
  output logic       frame_done,
  output logic       frame_error
);

  // Counters are wider than the output coordinates so oversize source
  // frames saturate into the "dropped" range instead of wrapping back in.
  localparam int CW = 12;
  localparam logic [CW-1:0] WIDTH_C  = CW'(IMG_WIDTH);
  localparam logic [CW-1:0] HEIGHT_C = CW'(IMG_HEIGHT);

  typedef enum logic [1:0] {
    WAIT_SYNC = 2'd0,
    ARMED     = 2'd1,
    LINE      = 2'd2
  } state_t;

  state_t          state, state_next;
  logic            vsync_prev, href_prev;
  logic            phase;          // 0: expecting high byte, 1: low byte
  logic [7:0]      hi_byte;
  logic [CW-1:0]   src_col, src_line;
  logic [CW-1:0]   line_px_cnt;    // pixels emitted on the current line
  logic [CW-1:0]   out_lines;      // kept source lines seen this frame
  logic            err_flag;
  logic            first_pending;  // no pixel emitted yet in this frame

  logic            vsync_fall, vsync_rise, href_fall;
  logic            byte_ok, pixel_done, pixel_kept, pixel_emit;
  logic            line_end, line_kept, line_bad;
  logic [CW-1:0]   x_calc, y_calc;
  logic [15:0]     rgb;

  assign vsync_fall = vsync_prev & ~cam_vsync;
  assign vsync_rise = ~vsync_prev & cam_vsync;
  assign href_fall  = href_prev & ~cam_href;

  // A byte counts only inside an armed frame, on an active line, and never
  // in the same cycle vsync asserts (vsync wins over everything).
  assign byte_ok    = cam_byte_en & cam_href & ~cam_vsync & (state != WAIT_SYNC);
  assign pixel_done = byte_ok & phase;
  assign rgb        = {hi_byte, cam_data};

  assign x_calc     = DECIMATE ? {1'b0, src_col[CW-1:1]}  : src_col;
  assign y_calc     = DECIMATE ? {1'b0, src_line[CW-1:1]} : src_line;
  assign line_kept  = DECIMATE ? ~src_line[0] : 1'b1;
  assign pixel_kept = line_kept & (DECIMATE ? ~src_col[0] : 1'b1);
  assign pixel_emit = pixel_done & pixel_kept & (x_calc < WIDTH_C) & (y_calc < HEIGHT_C);

  // A line ends on href fall; it is bad if a high byte is left dangling or,
  // for an in-range output line, the emitted pixel count is not the width.
  assign line_end   = (state == LINE) & href_fall & ~cam_vsync;
  assign line_bad   = phase | (line_kept & (y_calc < HEIGHT_C) & (line_px_cnt != WIDTH_C));

  // ---- FSM: state register ----
  always_ff @(posedge clk) begin
    if (reset) state <= WAIT_SYNC;
    else       state <= state_next;
  end

  // ---- FSM: next state ----
  // NOTE: every always_comb output gets a default before any branch; a path
  // that leaves it unassigned would infer a latch.
  always_comb begin
    state_next = state;
    if (cam_vsync) begin
      state_next = WAIT_SYNC;
    end else begin
      case (state)
        WAIT_SYNC: if (vsync_fall)               state_next = ARMED;
        ARMED:     if (cam_byte_en && cam_href)  state_next = LINE;
        LINE:      if (href_fall)                state_next = ARMED;
        default:                                 state_next = WAIT_SYNC;
      endcase
    end
  end

  // ---- Datapath, counters and registered outputs ----
  // NOTE: clocked state uses non-blocking assignments only, so every
  // right-hand side here reads the pre-edge value regardless of order.
  always_ff @(posedge clk) begin
    if (reset) begin
      vsync_prev    <= 1'b0;
      href_prev     <= 1'b0;
      phase         <= 1'b0;
      hi_byte       <= '0;
      src_col       <= '0;
      src_line      <= '0;
      line_px_cnt   <= '0;
      out_lines     <= '0;
      err_flag      <= 1'b0;
      first_pending <= 1'b0;
      red_out       <= '0;
      green_out     <= '0;
      blue_out      <= '0;
      valid_out     <= 1'b0;
      frame_start   <= 1'b0;
      x_out         <= '0;
      y_out         <= '0;
      frame_done    <= 1'b0;
      frame_error   <= 1'b0;
    end else begin
      vsync_prev  <= cam_vsync;
      href_prev   <= cam_href;
      valid_out   <= pixel_emit;
      frame_start <= pixel_emit & first_pending & (x_calc == '0) & (y_calc == '0);
      frame_done  <= 1'b0;
      frame_error <= 1'b0;

      if (pixel_emit) begin
        red_out   <= {rgb[15:11], rgb[15:13]};
        green_out <= {rgb[10:5],  rgb[10:9]};
        blue_out  <= {rgb[4:0],   rgb[4:2]};
        x_out     <= x_calc[8:0];
        y_out     <= y_calc[7:0];
      end

      if (cam_vsync) begin
        // Blanking: any half pixel is dropped. A line still open at the
        // rising edge was aborted, which makes the frame erroneous.
        phase    <= 1'b0;
        err_flag <= 1'b0;
        if (vsync_rise && state != WAIT_SYNC) begin
          frame_done  <= 1'b1;
          frame_error <= err_flag | (state == LINE) | (out_lines != HEIGHT_C);
        end
      end else if (vsync_fall) begin
        src_col       <= '0;
        src_line      <= '0;
        line_px_cnt   <= '0;
        out_lines     <= '0;
        phase         <= 1'b0;
        err_flag      <= 1'b0;
        first_pending <= 1'b1;
      end else begin
        if (byte_ok) begin
          if (!phase) begin
            hi_byte <= cam_data;
            phase   <= 1'b1;
          end else begin
            phase   <= 1'b0;
            src_col <= src_col + 1'b1;
          end
        end
        if (pixel_emit) begin
          line_px_cnt   <= line_px_cnt + 1'b1;
          first_pending <= 1'b0;
        end
        if (line_end) begin
          phase       <= 1'b0;
          src_col     <= '0;
          src_line    <= src_line + 1'b1;
          line_px_cnt <= '0;
          if (line_bad)  err_flag  <= 1'b1;
          if (line_kept) out_lines <= out_lines + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_image_capture_rgb565.sv
// ---------------------------------------------------------------------------
// tb_image_capture_rgb565
//   Drives one camera byte stream into two captures side by side:
//     dut 0: 4x2 output, no decimation
//     dut 1: 4x3 output, 2:1 decimation (8x6 source)
//   A reference model derives the expected pixels and frame_done/frame_error
//   from the bytes actually sent and compares them with what each capture
//   produced, including the cycle each pixel appeared.
// ---------------------------------------------------------------------------
module tb_image_capture_rgb565;

  typedef struct packed {
    logic [31:0] cyc;
    logic [7:0]  r;
    logic [7:0]  g;
    logic [7:0]  b;
    logic [8:0]  x;
    logic [7:0]  y;
    logic        fs;
  } pix_t;

  typedef struct packed {
    logic [31:0] cyc;
    logic        err;
  } done_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       cam_vsync, cam_href, cam_byte_en;
  logic [7:0] cam_data;

  logic [7:0] red_o   [2];
  logic [7:0] green_o [2];
  logic [7:0] blue_o  [2];
  logic       valid_o [2];
  logic       start_o [2];
  logic [8:0] x_o     [2];
  logic [7:0] y_o     [2];
  logic       done_o  [2];
  logic       err_o   [2];

  image_capture_rgb565 #(.IMG_WIDTH(4), .IMG_HEIGHT(2), .DECIMATE(1'b0)) dut0 (
    .clk(clk), .reset(reset), .cam_vsync(cam_vsync), .cam_href(cam_href),
    .cam_data(cam_data), .cam_byte_en(cam_byte_en),
    .red_out(red_o[0]), .green_out(green_o[0]), .blue_out(blue_o[0]),
    .valid_out(valid_o[0]), .frame_start(start_o[0]), .x_out(x_o[0]), .y_out(y_o[0]),
    .frame_done(done_o[0]), .frame_error(err_o[0])
  );

  image_capture_rgb565 #(.IMG_WIDTH(4), .IMG_HEIGHT(3), .DECIMATE(1'b1)) dut1 (
    .clk(clk), .reset(reset), .cam_vsync(cam_vsync), .cam_href(cam_href),
    .cam_data(cam_data), .cam_byte_en(cam_byte_en),
    .red_out(red_o[1]), .green_out(green_o[1]), .blue_out(blue_o[1]),
    .valid_out(valid_o[1]), .frame_start(start_o[1]), .x_out(x_o[1]), .y_out(y_o[1]),
    .frame_done(done_o[1]), .frame_error(err_o[1])
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  // Frame description and record of what was driven.
  logic [7:0] fb[$];   // bytes of the frame
  int         fl[$];   // byte count of each line
  int         bc[$];   // cycle each byte was presented
  bit         aborted;
  int         vr_cyc;  // cycle vsync was raised at frame end

  pix_t  obs_pix0[$], obs_pix1[$];
  done_t obs_done0[$], obs_done1[$];
  pix_t  exp_pix[$];
  done_t exp_done;

  function automatic pix_t mk_pix(input int c, input logic [15:0] w, input int x,
                                  input int y, input bit fs);
    pix_t p;
    p.cyc = 32'(c);
    p.r   = {w[15:11], w[15:13]};
    p.g   = {w[10:5],  w[10:9]};
    p.b   = {w[4:0],   w[4:2]};
    p.x   = 9'(x);
    p.y   = 8'(y);
    p.fs  = fs;
    return p;
  endfunction

  function automatic pix_t obs_pix(input int k);
    pix_t p;
    p.cyc = 32'(cyc);
    p.r   = red_o[k];
    p.g   = green_o[k];
    p.b   = blue_o[k];
    p.x   = x_o[k];
    p.y   = y_o[k];
    p.fs  = start_o[k];
    return p;
  endfunction

  function automatic done_t obs_dn(input int k);
    done_t d;
    d.cyc = 32'(cyc);
    d.err = err_o[k];
    return d;
  endfunction

  always @(negedge clk) begin
    if (valid_o[0]) obs_pix0.push_back(obs_pix(0));
    if (valid_o[1]) obs_pix1.push_back(obs_pix(1));
    if (done_o[0])  obs_done0.push_back(obs_dn(0));
    if (done_o[1])  obs_done1.push_back(obs_dn(1));
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] expv);
    n_checks++;
    assert (got === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] d);
    cam_byte_en = 1'b1;
    cam_data    = d;
    bc.push_back(cyc);
    tick();
    cam_byte_en = 1'b0;
    cam_data    = 8'($urandom);
    repeat ($urandom_range(1, 2)) tick();
  endtask

  task automatic clear_frame();
    fb.delete();
    fl.delete();
    aborted = 1'b0;
  endtask

  task automatic add_rand_lines(input int nlines, input int nbytes);
    for (int l = 0; l < nlines; l++) begin
      for (int j = 0; j < nbytes; j++) fb.push_back(8'($urandom));
      fl.push_back(nbytes);
    end
  endtask

  task automatic add_word(input logic [15:0] w);
    fb.push_back(w[15:8]);
    fb.push_back(w[7:0]);
  endtask

  // vsync high -> low, every line of fb/fl, then vsync high again. An aborted
  // frame raises vsync while href is still high on its last line.
  task automatic send_frame();
    int base = 0;
    bc.delete();
    cam_vsync = 1'b1;
    cam_href  = 1'b0;
    repeat (3) tick();
    cam_vsync = 1'b0;
    repeat (2) tick();
    for (int li = 0; li < fl.size(); li++) begin
      cam_href = 1'b1;
      for (int j = 0; j < fl[li]; j++) send_byte(fb[base + j]);
      base += fl[li];
      if (!(aborted && li == fl.size() - 1)) begin
        cam_href    = 1'b0;
        cam_byte_en = 1'b1;          // stray strobe outside href: ignored
        cam_data    = 8'($urandom);
        tick();
        cam_byte_en = 1'b0;
        repeat (2) tick();
      end
    end
    cam_vsync = 1'b1;
    vr_cyc    = cyc;
    tick();
    cam_href = 1'b0;
    repeat (3) tick();
  endtask

  // Reference: walk the recorded frame line by line and pixel by pixel.
  task automatic build_expect(input bit d, input int w, input int h);
    int  base      = 0;
    int  lines_out = 0;
    bit  err       = 1'b0;
    bit  first     = 1'b1;
    exp_pix.delete();
    for (int li = 0; li < fl.size(); li++) begin
      int n   = fl[li];
      int y   = d ? li / 2 : li;
      bit lk  = d ? (li % 2 == 0) : 1'b1;
      int cnt = 0;
      for (int p = 0; p < n / 2; p++) begin
        logic [15:0] wd   = {fb[base + 2*p], fb[base + 2*p + 1]};
        int          x    = d ? p / 2 : p;
        bit          keep = d ? (lk && p % 2 == 0) : 1'b1;
        if (keep && x < w && y < h) begin
          exp_pix.push_back(mk_pix(bc[base + 2*p + 1] + 1, wd, x, y, first && x == 0 && y == 0));
          first = 1'b0;
          cnt++;
        end
      end
      if (aborted && li == fl.size() - 1) begin
        err = 1'b1;
      end else begin
        if (n % 2 != 0) err = 1'b1;
        if (lk && y < h && cnt != w) err = 1'b1;
        if (lk) lines_out++;
      end
      base += n;
    end
    if (lines_out != h) err = 1'b1;
    exp_done.cyc = 32'(vr_cyc + 1);
    exp_done.err = err;
  endtask

  task automatic compare(input int k, input bit d, input int w, input int h, input string name);
    pix_t  got[$];
    done_t gd[$];
    build_expect(d, w, h);
    if (k == 0) begin
      got = obs_pix0;  gd = obs_done0;
      obs_pix0.delete(); obs_done0.delete();
    end else begin
      got = obs_pix1;  gd = obs_done1;
      obs_pix1.delete(); obs_done1.delete();
    end
    check({name, "/npix"}, 128'(got.size()), 128'(exp_pix.size()));
    for (int i = 0; i < got.size() && i < exp_pix.size(); i++)
      check($sformatf("%s/pix%0d", name, i), 128'(got[i]), 128'(exp_pix[i]));
    check({name, "/ndone"}, 128'(gd.size()), 128'(1));
    if (gd.size() > 0) check({name, "/done"}, 128'(gd[0]), 128'(exp_done));
  endtask

  task automatic check_idle(input string name);
    check({name, "/npix0"},  128'(obs_pix0.size()),  128'(0));
    check({name, "/ndone0"}, 128'(obs_done0.size()), 128'(0));
    check({name, "/npix1"},  128'(obs_pix1.size()),  128'(0));
    check({name, "/ndone1"}, 128'(obs_done1.size()), 128'(0));
  endtask

  task automatic check_zero(input string name);
    for (int k = 0; k < 2; k++)
      check($sformatf("%s/outs%0d", name, k),
            128'({red_o[k], green_o[k], blue_o[k], valid_o[k], start_o[k],
                  x_o[k], y_o[k], done_o[k], err_o[k]}), 128'(0));
  endtask

  initial begin
    pix_t last;
    reset       = 1'b1;
    cam_vsync   = 1'b0;
    cam_href    = 1'b0;
    cam_byte_en = 1'b0;
    cam_data    = 8'h00;
    aborted     = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    check_zero("reset");

    // No vsync high->low seen yet: bytes must be ignored.
    cam_href = 1'b1;
    for (int j = 0; j < 8; j++) send_byte(8'($urandom));
    cam_href = 1'b0;
    repeat (3) tick();
    check_idle("nosync");

    // 4x2 frame of pure red.
    clear_frame();
    for (int j = 0; j < 8; j++) add_word(16'hF800);
    fl.push_back(8);
    fl.push_back(8);
    send_frame();
    compare(0, 1'b0, 4, 2, "red0");
    compare(1, 1'b1, 4, 3, "red1");

    // Colour corners and a mid-grey, then random words.
    clear_frame();
    add_word(16'h07E0);
    add_word(16'h001F);
    add_word(16'h8410);
    for (int j = 0; j < 5; j++) add_word(16'($urandom));
    fl.push_back(8);
    fl.push_back(8);
    send_frame();
    compare(0, 1'b0, 4, 2, "col0");
    last = exp_pix[exp_pix.size() - 1];
    check("hold0", 128'({red_o[0], green_o[0], blue_o[0], x_o[0], y_o[0], valid_o[0]}),
          128'({last.r, last.g, last.b, last.x, last.y, 1'b0}));
    compare(1, 1'b1, 4, 3, "col1");

    // Random 8x6 source frame: the decimated capture sees exactly 4x3.
    clear_frame();
    add_rand_lines(6, 16);
    send_frame();
    compare(0, 1'b0, 4, 2, "dec0");
    compare(1, 1'b1, 4, 3, "dec1");

    // A single line with an odd byte count.
    clear_frame();
    add_rand_lines(1, 7);
    send_frame();
    compare(0, 1'b0, 4, 2, "odd0");
    compare(1, 1'b1, 4, 3, "odd1");

    // Oversize source: pixels beyond width/height are dropped.
    clear_frame();
    add_rand_lines(7, 20);
    send_frame();
    compare(0, 1'b0, 4, 2, "big0");
    compare(1, 1'b1, 4, 3, "big1");

    // Vsync rises right after the high byte of a pixel on the third line.
    clear_frame();
    add_rand_lines(2, 8);
    add_rand_lines(1, 5);
    aborted = 1'b1;
    send_frame();
    compare(0, 1'b0, 4, 2, "abort0");
    compare(1, 1'b1, 4, 3, "abort1");

    // Reset in mid-frame with vsync low: nothing more until a new frame.
    clear_frame();
    cam_vsync = 1'b1;
    repeat (3) tick();
    cam_vsync = 1'b0;
    repeat (2) tick();
    cam_href = 1'b1;
    for (int j = 0; j < 10; j++) send_byte(8'($urandom));
    check("prerst0", 128'(obs_pix0.size()), 128'(4));
    check("prerst1", 128'(obs_pix1.size()), 128'(3));
    obs_pix0.delete();
    obs_pix1.delete();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_zero("midrst");
    for (int j = 0; j < 6; j++) send_byte(8'($urandom));
    cam_href = 1'b0;
    repeat (2) tick();
    cam_href = 1'b1;
    for (int j = 0; j < 16; j++) send_byte(8'($urandom));
    cam_href = 1'b0;
    repeat (2) tick();
    cam_vsync = 1'b1;
    repeat (3) tick();
    check_idle("postrst");

    // Next frame is captured cleanly from (0,0).
    clear_frame();
    add_rand_lines(6, 16);
    send_frame();
    compare(0, 1'b0, 4, 2, "clean0");
    compare(1, 1'b1, 4, 3, "clean1");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
